// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-FU holding slots for finish pulses, round-robin grant
// onto the single register-file/scoreboard writeback port.
module fu_wb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_FU-1:0]        fu_finish,
   input  logic [NUM_FU*DATA_W-1:0] fu_res,
   input  logic [NUM_FU*RD_W-1:0]   fu_rd,
   output logic [NUM_FU-1:0]        fu_ready,
   output logic                     wb_valid,
   output logic                     wb_we,
   output logic [RD_W-1:0]          wb_rd,
   output logic [DATA_W-1:0]        wb_data,
   output logic [SRC_W-1:0]         wb_src,
   output logic [NUM_FU-1:0]        ovf_err
);

   logic [NUM_FU-1:0] hold_v;
   logic [RD_W-1:0]   hold_rd   [NUM_FU];
   logic [DATA_W-1:0] hold_data [NUM_FU];
   logic [SRC_W-1:0]  rr_ptr;

   logic [NUM_FU-1:0] grant;
   logic [SRC_W-1:0]  gnt_idx;
   logic [SRC_W-1:0]  cand;
   logic              gnt_any;

   // First valid slot at or above rr_ptr, wrapping modulo NUM_FU.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         cand = SRC_W'((32'(rr_ptr) + k) % NUM_FU);
         if (!gnt_any && hold_v[cand]) begin
            grant[cand] = 1'b1;
            gnt_idx     = cand;
            gnt_any     = 1'b1;
         end
      end
   end

   // A slot being drained this cycle may be refilled at the same edge.
   assign fu_ready = ~hold_v | grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v   <= '0;
         rr_ptr   <= '0;
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         wb_src   <= '0;
         ovf_err  <= '0;
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            hold_rd[i]   <= '0;
            hold_data[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fu_finish[i] && fu_ready[i]) begin
               hold_v[i]    <= 1'b1;
               hold_rd[i]   <= fu_rd[i*RD_W +: RD_W];
               hold_data[i] <= fu_res[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               hold_v[i] <= 1'b0;
            end
            if (fu_finish[i] && !fu_ready[i])
               ovf_err[i] <= 1'b1;
         end

         wb_valid <= gnt_any;
         wb_we    <= gnt_any && (hold_rd[gnt_idx] != '0);
         if (gnt_any) begin
            wb_rd   <= hold_rd[gnt_idx];
            wb_data <= hold_data[gnt_idx];
            wb_src  <= gnt_idx;
            rr_ptr  <= (int'(gnt_idx) == NUM_FU - 1) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed-vector bench for fu_wb_arbiter; expected writebacks go into a
// scoreboard queue and a negedge monitor pops/compares on every wb_valid.
module tb_fu_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   fu_finish;
   logic [127:0] fu_res;
   logic [19:0]  fu_rd;
   logic [3:0]   fu_ready;
   logic         wb_valid;
   logic         wb_we;
   logic [4:0]   wb_rd;
   logic [31:0]  wb_data;
   logic [1:0]   wb_src;
   logic [3:0]   ovf_err;

   fu_wb_arbiter #(.NUM_FU(4), .DATA_W(32), .RD_W(5)) dut (
      .clk(clk), .rst(rst), .fu_finish(fu_finish), .fu_res(fu_res), .fu_rd(fu_rd),
      .fu_ready(fu_ready), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_src(wb_src), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int pcnt = 0;
   always @(posedge clk) pcnt <= pcnt + 1;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [1:0]  src;
      logic        we;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (posedge %0d)", name, act, exp, pcnt);
      end
   endfunction

   function automatic void push(input logic [4:0] rd, input logic [31:0] data,
                                input logic [1:0] src, input int cyc);
      exp_t e;
      e.rd = rd; e.data = data; e.src = src; e.we = (rd != 5'd0); e.cyc = cyc;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_wb: got src=%0d rd=%0d data=0x%0h expected no writeback (posedge %0d)",
                     wb_src, wb_rd, wb_data, pcnt);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wb_cycle", 32'(pcnt), 32'(e.cyc));
            check("wb_src", 32'(wb_src), 32'(e.src));
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_data", wb_data, e.data);
            check("wb_we", 32'(wb_we), 32'(e.we));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_fu(input int i, input logic [4:0] rd, input logic [31:0] d);
      fu_finish[i]       = 1'b1;
      fu_res[i*32 +: 32] = d;
      fu_rd[i*5 +: 5]    = rd;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      check({tag, "_wb_we"},    32'(wb_we),    32'd0);
      check({tag, "_wb_rd"},    32'(wb_rd),    32'd0);
      check({tag, "_wb_data"},  wb_data,       32'd0);
      check({tag, "_wb_src"},   32'(wb_src),   32'd0);
      check({tag, "_ovf_err"},  32'(ovf_err),  32'd0);
   endtask

   initial begin
      int p;
      rst = 1'b1; fu_finish = '0; fu_res = '0; fu_rd = '0;
      idle(2);
      rst = 1'b0;
      check_reset_outputs("rst");
      tick();
      check("ready_after_rst", 32'(fu_ready), 32'hF);

      // Single DIV finish: rd=5, data=7, two-cycle latency
      p = pcnt;
      set_fu(3, 5'd5, 32'h7);
      push(5'd5, 32'h7, 2'd3, p + 2);
      tick(); fu_finish = '0;
      idle(4);

      // All four finish together, rr_ptr=0 -> src 0,1,2,3
      p = pcnt;
      for (int i = 0; i < 4; i++) begin
         set_fu(i, 5'(i + 1), 32'h100 + 32'(i));
         push(5'(i + 1), 32'h100 + 32'(i), 2'(i), p + 2 + i);
      end
      tick(); fu_finish = '0;
      check("ready_all_held", 32'(fu_ready), 32'h1);
      tick(); check("ready_g1", 32'(fu_ready), 32'h3);
      tick(); check("ready_g2", 32'(fu_ready), 32'h7);
      tick(); check("ready_g3", 32'(fu_ready), 32'hF);
      idle(3);

      // Pointer rotation: last grant slot 2, then slots 1 and 3 -> 3 first
      p = pcnt;
      set_fu(2, 5'd6, 32'h22);
      push(5'd6, 32'h22, 2'd2, p + 2);
      tick(); fu_finish = '0;
      idle(2);
      p = pcnt;
      set_fu(1, 5'd10, 32'h11);
      set_fu(3, 5'd12, 32'h33);
      push(5'd12, 32'h33, 2'd3, p + 2);
      push(5'd10, 32'h11, 2'd1, p + 3);
      tick(); fu_finish = '0;
      idle(4);

      // Back-to-back MUL finishes
      p = pcnt;
      set_fu(2, 5'd7, 32'hA);
      push(5'd7, 32'hA, 2'd2, p + 2);
      tick();
      set_fu(2, 5'd8, 32'hB);
      push(5'd8, 32'hB, 2'd2, p + 3);
      tick(); fu_finish = '0;
      idle(3);
      check("ovf_b2b", 32'(ovf_err), 32'h0);

      // Set rr_ptr=1 via a lone ALU grant, then overflow on slot 0
      p = pcnt;
      set_fu(0, 5'd9, 32'h55);
      push(5'd9, 32'h55, 2'd0, p + 2);
      tick(); fu_finish = '0;
      idle(3);
      p = pcnt;
      set_fu(0, 5'd0,  32'hA0);
      set_fu(1, 5'd11, 32'hB1);
      set_fu(2, 5'd12, 32'hB2);
      set_fu(3, 5'd13, 32'hB3);
      push(5'd11, 32'hB1, 2'd1, p + 2);
      push(5'd12, 32'hB2, 2'd2, p + 3);
      push(5'd13, 32'hB3, 2'd3, p + 4);
      push(5'd0,  32'hA0, 2'd0, p + 5);
      tick(); fu_finish = '0;
      set_fu(0, 5'd15, 32'hDEAD);
      tick(); fu_finish = '0;
      check("ovf_set", 32'(ovf_err), 32'h1);
      check("ready_during_drain", 32'(fu_ready), 32'h6);
      idle(5);
      check("ovf_sticky", 32'(ovf_err), 32'h1);

      // Reset with results held: discarded, outputs back to reset values
      set_fu(1, 5'd20, 32'h77);
      set_fu(2, 5'd21, 32'h88);
      tick(); fu_finish = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("midrst");
      check("ready_midrst", 32'(fu_ready), 32'hF);
      idle(6);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
